// File: rtl/kernel_resp_misr_if.sv
// -----------------------------------------------------------------------------
// kernel_resp_misr_if
// Handshake bus that carries one kernel input vector and the kernel's response
// from the stimulus source to the response compactor.
//   in_valid : source -> compactor, a vector/response pair is presented
//   in_ready : compactor -> source, the pair is accepted this cycle
//   in_vec   : source -> compactor, kernel input vector (LSB = lowest index)
//   in_resp  : source -> compactor, kernel output for in_vec
// Modports: master = stimulus source, slave = compactor.
// -----------------------------------------------------------------------------
interface kernel_resp_misr_if #(
  parameter int VEC_W = 15
) ();
  logic             in_valid;
  logic             in_ready;
  logic [VEC_W-1:0] in_vec;
  logic             in_resp;

  modport master (
    output in_valid,
    output in_vec,
    output in_resp,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_vec,
    input  in_resp,
    output in_ready
  );
endinterface

// File: rtl/kernel_resp_misr.sv
// -----------------------------------------------------------------------------
// kernel_resp_misr
// Response compactor for the combinational kernel_2_2 benchmark kernel. Each
// accepted {vector, response} pair is folded into a MISR; accepted pairs and
// ones responses are counted. After the programmed number of pairs the
// signature is compared against an expected value and a pass flag reported.
//
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   s_in       : pair handshake bus (slave side), see kernel_resp_misr_if
//   i_start    : one-cycle pulse, latches i_num_vec / i_exp_sig, starts a run
//   i_num_vec  : pairs in the run (sampled on i_start)
//   i_exp_sig  : expected final signature (sampled on i_start)
//   o_sig      : current signature
//   o_vec_cnt  : pairs accepted in this run
//   o_ones_cnt : accepted pairs whose response was 1
//   o_busy     : run or compare in progress
//   o_done     : run finished, o_pass valid
//   o_pass     : signature matched the expected value
// -----------------------------------------------------------------------------
module kernel_resp_misr #(
  parameter int               VEC_W = 15,
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = 16'h1021,
  parameter logic [SIG_W-1:0] SEED  = 16'h0000,
  parameter int               CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  kernel_resp_misr_if.slave   s_in,
  input  logic                i_start,
  input  logic [CNT_W-1:0]    i_num_vec,
  input  logic [SIG_W-1:0]    i_exp_sig,
  output logic [SIG_W-1:0]    o_sig,
  output logic [CNT_W-1:0]    o_vec_cnt,
  output logic [CNT_W-1:0]    o_ones_cnt,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_pass
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           r_state,     w_state_next;
  logic [SIG_W-1:0] r_sig,       w_sig_next;
  logic [CNT_W-1:0] r_vec_cnt,   w_vec_cnt_next;
  logic [CNT_W-1:0] r_ones_cnt,  w_ones_cnt_next;
  logic [CNT_W-1:0] r_num_vec,   w_num_vec_next;
  logic [SIG_W-1:0] r_exp_sig,   w_exp_sig_next;
  logic             r_pass,      w_pass_next;

  logic             w_accept;
  logic [SIG_W-1:0] w_d;
  logic [SIG_W-1:0] w_misr;
  logic [CNT_W-1:0] w_vec_cnt_inc;

  // Handshake and status decode straight from the registered state, so there
  // is no combinational path from in_valid back to in_ready.
  assign s_in.in_ready = (r_state == ST_RUN);
  assign o_busy        = (r_state == ST_RUN) || (r_state == ST_CHECK);
  assign o_done        = (r_state == ST_DONE);
  assign o_sig         = r_sig;
  assign o_vec_cnt     = r_vec_cnt;
  assign o_ones_cnt    = r_ones_cnt;
  assign o_pass        = r_pass;

  assign w_accept      = (r_state == ST_RUN) && s_in.in_valid;

  // Response sits in bit 0, vector above it, zero-extended to the MISR width.
  assign w_d           = SIG_W'({s_in.in_vec, s_in.in_resp});
  assign w_misr        = (r_sig << 1) ^ (r_sig[SIG_W-1] ? POLY : '0) ^ w_d;
  assign w_vec_cnt_inc = r_vec_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_sig      <= SEED;
      r_vec_cnt  <= '0;
      r_ones_cnt <= '0;
      r_num_vec  <= '0;
      r_exp_sig  <= '0;
      r_pass     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_sig      <= w_sig_next;
      r_vec_cnt  <= w_vec_cnt_next;
      r_ones_cnt <= w_ones_cnt_next;
      r_num_vec  <= w_num_vec_next;
      r_exp_sig  <= w_exp_sig_next;
      r_pass     <= w_pass_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_sig_next      = r_sig;
    w_vec_cnt_next  = r_vec_cnt;
    w_ones_cnt_next = r_ones_cnt;
    w_num_vec_next  = r_num_vec;
    w_exp_sig_next  = r_exp_sig;
    w_pass_next     = r_pass;

    unique case (r_state)
      // IDLE and DONE share the same start/load behaviour; DONE just holds
      // its results until re-armed.
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_sig_next      = SEED;
          w_vec_cnt_next  = '0;
          w_ones_cnt_next = '0;
          w_pass_next     = 1'b0;
          w_num_vec_next  = i_num_vec;
          w_exp_sig_next  = i_exp_sig;
          w_state_next    = (i_num_vec == '0) ? ST_CHECK : ST_RUN;
        end
      end

      // i_start is deliberately not looked at here.
      ST_RUN: begin
        if (w_accept) begin
          w_sig_next      = w_misr;
          w_vec_cnt_next  = w_vec_cnt_inc;
          w_ones_cnt_next = r_ones_cnt + CNT_W'(s_in.in_resp);
          if (w_vec_cnt_inc == r_num_vec) begin
            w_state_next = ST_CHECK;
          end
        end
      end

      ST_CHECK: begin
        w_pass_next  = (r_sig == r_exp_sig);
        w_state_next = ST_DONE;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_kernel_resp_misr.sv
module tb_kernel_resp_misr;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] num_vec;
  logic [15:0] exp_sig;
  logic [15:0] sig;
  logic [15:0] vec_cnt;
  logic [15:0] ones_cnt;
  logic        busy;
  logic        done;
  logic        pass;

  int n_checks = 0;
  int n_pass   = 0;

  kernel_resp_misr_if #(.VEC_W(15)) bus ();

  kernel_resp_misr #(
    .VEC_W (15),
    .SIG_W (16),
    .POLY  (16'h1021),
    .SEED  (16'h0000),
    .CNT_W (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_in       (bus.slave),
    .i_start    (start),
    .i_num_vec  (num_vec),
    .i_exp_sig  (exp_sig),
    .o_sig      (sig),
    .o_vec_cnt  (vec_cnt),
    .o_ones_cnt (ones_cnt),
    .o_busy     (busy),
    .o_done     (done),
    .o_pass     (pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [15:0] num;
    logic [15:0] exp;
    logic        valid;
    logic [14:0] vec;
    logic        resp;
    logic [15:0] e_sig;
    logic [15:0] e_vc;
    logic [15:0] e_oc;
    logic        e_ready;
    logic        e_busy;
    logic        e_done;
    logic        e_pass;
  } row_t;

  row_t tbl [24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " sig"},      32'(sig),          32'h0);
    chk({tag, " vec_cnt"},  32'(vec_cnt),      32'h0);
    chk({tag, " ones_cnt"}, 32'(ones_cnt),     32'h0);
    chk({tag, " in_ready"}, 32'(bus.in_ready), 32'h0);
    chk({tag, " busy"},     32'(busy),         32'h0);
    chk({tag, " done"},     32'(done),         32'h0);
    chk({tag, " pass"},     32'(pass),         32'h0);
  endtask

  // Stand-in for the kernel_2_2 combinational function.
  function automatic logic kernel(input logic [14:0] v);
    return (^v[14:8]) ^ (v[0] & v[5]) ^ (v[3] | v[11]) ^ (v[2] & ~v[13]);
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [14:0] v, input logic r);
    logic [15:0] fb;
    fb = s[15] ? 16'h1021 : 16'h0000;
    return {s[14:0], 1'b0} ^ fb ^ {v, r};
  endfunction

  initial begin
    // start num exp valid vec resp | sig vc oc ready busy done pass
    tbl[0]  = '{1'b1, 16'd2, 16'h0002, 1'b0, 15'h0000, 1'b0, 16'h0000, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 16'd0, 16'h0000, 1'b1, 15'h0000, 1'b1, 16'h0001, 16'd1, 16'd1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 16'd0, 16'h0000, 1'b1, 15'h0000, 1'b0, 16'h0002, 16'd2, 16'd1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 16'd0, 16'h0000, 1'b0, 15'h0000, 1'b0, 16'h0002, 16'd2, 16'd1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 16'd0, 16'h0000, 1'b1, 15'h1234, 1'b1, 16'h0002, 16'd2, 16'd1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 16'd2, 16'hEFDF, 1'b0, 15'h0000, 1'b0, 16'h0000, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 16'd0, 16'h0000, 1'b1, 15'h7FFF, 1'b1, 16'hFFFF, 16'd1, 16'd1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 16'd0, 16'h0000, 1'b1, 15'h0000, 1'b0, 16'hEFDF, 16'd2, 16'd1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 16'd0, 16'h0000, 1'b0, 15'h0000, 1'b0, 16'hEFDF, 16'd2, 16'd1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 16'd2, 16'h0000, 1'b0, 15'h0000, 1'b0, 16'h0000, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 16'd0, 16'h0000, 1'b1, 15'h7FFF, 1'b1, 16'hFFFF, 16'd1, 16'd1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 16'd0, 16'h0000, 1'b1, 15'h0000, 1'b0, 16'hEFDF, 16'd2, 16'd1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 16'd0, 16'h0000, 1'b0, 15'h0000, 1'b0, 16'hEFDF, 16'd2, 16'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 16'd3, 16'h000F, 1'b0, 15'h0000, 1'b0, 16'h0000, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 16'd0, 16'h0000, 1'b1, 15'h0001, 1'b0, 16'h0002, 16'd1, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 16'd0, 16'h0000, 1'b0, 15'h7FFF, 1'b1, 16'h0002, 16'd1, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 16'd0, 16'h0000, 1'b1, 15'h0000, 1'b1, 16'h0005, 16'd2, 16'd1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 16'd9, 16'h0000, 1'b0, 15'h7FFF, 1'b1, 16'h0005, 16'd2, 16'd1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 16'd9, 16'h0000, 1'b1, 15'h0002, 1'b1, 16'h000F, 16'd3, 16'd2, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 16'd0, 16'h0000, 1'b0, 15'h0000, 1'b0, 16'h000F, 16'd3, 16'd2, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[20] = '{1'b1, 16'd0, 16'h0000, 1'b0, 15'h0000, 1'b0, 16'h0000, 16'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[21] = '{1'b0, 16'd0, 16'h0000, 1'b1, 15'h7FFF, 1'b1, 16'h0000, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[22] = '{1'b1, 16'd0, 16'h1234, 1'b0, 15'h0000, 1'b0, 16'h0000, 16'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[23] = '{1'b0, 16'd0, 16'h0000, 1'b0, 15'h0000, 1'b0, 16'h0000, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0};

    rst_n        = 1'b0;
    start        = 1'b0;
    num_vec      = 16'd0;
    exp_sig      = 16'h0000;
    bus.in_valid = 1'b0;
    bus.in_vec   = 15'h0000;
    bus.in_resp  = 1'b0;

    #2;
    chk_reset_outputs("reset");
    $display("txn reset: sig=%h vec_cnt=%0d done=%0d", sig, vec_cnt, done);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk_reset_outputs("post-reset idle");

    // Table-driven directed vectors.
    for (int i = 0; i < 24; i++) begin
      start        = tbl[i].start;
      num_vec      = tbl[i].num;
      exp_sig      = tbl[i].exp;
      bus.in_valid = tbl[i].valid;
      bus.in_vec   = tbl[i].vec;
      bus.in_resp  = tbl[i].resp;
      step();
      chk($sformatf("row%0d sig", i),      32'(sig),          32'(tbl[i].e_sig));
      chk($sformatf("row%0d vec_cnt", i),  32'(vec_cnt),      32'(tbl[i].e_vc));
      chk($sformatf("row%0d ones_cnt", i), 32'(ones_cnt),     32'(tbl[i].e_oc));
      chk($sformatf("row%0d in_ready", i), 32'(bus.in_ready), 32'(tbl[i].e_ready));
      chk($sformatf("row%0d busy", i),     32'(busy),         32'(tbl[i].e_busy));
      chk($sformatf("row%0d done", i),     32'(done),         32'(tbl[i].e_done));
      chk($sformatf("row%0d pass", i),     32'(pass),         32'(tbl[i].e_pass));
      $display("txn row%0d: start=%0d valid=%0d vec=%h resp=%0d -> sig=%h vc=%0d oc=%0d rdy=%0d busy=%0d done=%0d pass=%0d",
               i, tbl[i].start, tbl[i].valid, tbl[i].vec, tbl[i].resp,
               sig, vec_cnt, ones_cnt, bus.in_ready, busy, done, pass);
    end
    start        = 1'b0;
    bus.in_valid = 1'b0;

    // Asynchronous reset in the middle of a run.
    num_vec = 16'd5;
    exp_sig = 16'h0000;
    start   = 1'b1;
    step();
    start        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_vec   = 15'h7FFF;
    bus.in_resp  = 1'b1;
    step();
    bus.in_vec   = 15'h0011;
    step();
    chk("midrun pre-reset vec_cnt", 32'(vec_cnt), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrun reset");
    $display("txn midrun reset: sig=%h vec_cnt=%0d busy=%0d", sig, vec_cnt, busy);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    step();
    chk_reset_outputs("after release valid high");
    bus.in_valid = 1'b0;

    // Exhaustive sweep over every kernel input vector.
    begin
      logic [15:0] ref_sig;
      logic [15:0] ref_ones;
      logic [14:0] v;
      int          waited;
      ref_sig  = 16'h0000;
      ref_ones = 16'd0;
      for (int i = 0; i < 32768; i++) begin
        v        = 15'(i);
        ref_sig  = misr_step(ref_sig, v, kernel(v));
        ref_ones = ref_ones + 16'(kernel(v));
      end
      num_vec = 16'h8000;
      exp_sig = ref_sig;
      start   = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 32768; i++) begin
        v            = 15'(i);
        bus.in_valid = 1'b1;
        bus.in_vec   = v;
        bus.in_resp  = kernel(v);
        step();
      end
      bus.in_valid = 1'b0;
      waited = 0;
      while (!done && waited < 8) begin
        step();
        waited++;
      end
      chk("sweep done reached", 32'(done), 32'd1);
      chk("sweep done latency", 32'(waited), 32'd1);
      chk("sweep pass",     32'(pass),     32'd1);
      chk("sweep sig",      32'(sig),      32'(ref_sig));
      chk("sweep vec_cnt",  32'(vec_cnt),  32'h8000);
      chk("sweep ones_cnt", 32'(ones_cnt), 32'(ref_ones));
      $display("txn sweep: sig=%h ref=%h vec_cnt=%0d ones=%0d ref_ones=%0d pass=%0d",
               sig, ref_sig, vec_cnt, ones_cnt, ref_ones, pass);
    end

    // Asynchronous reset while holding results in DONE.
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("done reset");
    $display("txn done reset: sig=%h pass=%0d done=%0d", sig, pass, done);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/kernel_resp_misr.md
# kernel_resp_misr

Downstream response compactor for the combinational `kernel_2_2` benchmark kernel, i.e. the stage that consumes the kernel's 15-bit input vector together with its 1-bit output. Each accepted vector/response pair is folded into a multiple-input signature register (MISR), and the block counts vectors and ones. After a programmed number of vectors it compares the signature against an expected value and reports pass/fail. It sits between the testbench stimulus source and the result/scoreboard logic of the benchmark harness.

## Interface
- `VEC_W`, 15, kernel input vector width; `VEC_W+1 <= SIG_W` is required.
- `SIG_W`, 16, MISR width.
- `POLY`, 16'h1021, MISR feedback polynomial, applied when the signature MSB is 1.
- `SEED`, 16'h0000, MISR value loaded on start.
- `CNT_W`, 16, width of the vector and ones counters.

- `clk`  in  1  clock, rising-edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle pulse; latches `num_vec` and `exp_sig` and begins a run.
- `num_vec`  in  CNT_W  number of vectors in the run, sampled on `start`.
- `exp_sig`  in  SIG_W  expected final signature, sampled on `start`.
- `in_valid`  in  1  upstream pair valid.
- `in_ready`  out  1  block accepts a pair this cycle.
- `in_vec`  in  VEC_W  kernel input vector (i_2_2_* bits, LSB = lowest index).
- `in_resp`  in  1  kernel output (o_2_2_0_0) for `in_vec`.
- `sig`  out  SIG_W  current signature.
- `vec_cnt`  out  CNT_W  pairs accepted in this run.
- `ones_cnt`  out  CNT_W  accepted pairs with `in_resp=1`.
- `busy`  out  1  high in RUN or CHECK.
- `done`  out  1  high in DONE.
- `pass`  out  1  compare result, valid while `done=1`.

## Operation
- FSM states: IDLE, RUN, CHECK, DONE.
- IDLE:
  - `in_ready=0`.
  - `start` loads `sig<=SEED`, clears `vec_cnt` and `ones_cnt`, clears `pass`, and latches `num_vec` and `exp_sig`.
  - Next state is RUN, or CHECK if `num_vec==0`.
- RUN:
  - `in_ready=1`.
  - A pair is accepted when `in_valid & in_ready`.
  - On accept: `d = {{(SIG_W-VEC_W-1){0}}, in_vec, in_resp}`.
  - `sig <= (sig<<1) ^ (sig[SIG_W-1] ? POLY : 0) ^ d`.
  - `vec_cnt += 1`; `ones_cnt += in_resp`.
  - When the accept makes `vec_cnt+1 == num_vec`, next state is CHECK.
  - `start` is ignored in RUN.
- CHECK:
  - `in_ready=0`.
  - Register `pass <= (sig == exp_sig)`, then go to DONE.
- DONE:
  - `done=1`; `sig`, the counters and `pass` hold.
  - `start` re-arms with the same load action as in IDLE; `done` drops the next cycle.
- Counters cannot wrap, because accepts are bounded by `num_vec <= 2^CNT_W-1`.
- `in_vec` and `in_resp` are ignored whenever no accept occurs.

## Timing
- Reset values: state IDLE, `sig=SEED`, `vec_cnt=0`, `ones_cnt=0`, `in_ready=0`, `busy=0`, `done=0`, `pass=0`.
- `in_ready`, `busy` and `done` decode directly from the registered state; there is no combinational path from `in_valid` to `in_ready`.
- Start at edge T0: `in_ready=1` from T0 through the final-accept edge.
- Throughput: one pair per cycle, with no bubbles while `in_valid` stays high.
- Latency after the final accept at edge Tn:
  - `sig` and counters are updated at Tn.
  - CHECK occupies Tn..Tn+1.
  - `done=1` and `pass` are valid from Tn+1.
- With `num_vec=0`: `done=1` two edges after `start`, and `pass = (SEED==exp_sig)`.
- Reset asserted mid-run: all outputs return to their reset values immediately (asynchronous). Release is synchronous to the next `clk` edge; the block stays in IDLE until `start`.
- `start` arriving in the same cycle as an accept in RUN is ignored; the accept proceeds.

## Test plan
- Reset, then start with `num_vec=2`, `exp_sig=16'h0002`; pairs (vec 0, resp 1), (vec 0, resp 0) -> `sig` 0x0001 then 0x0002, `ones_cnt=1`, `vec_cnt=2`, `done` at Tn+1, `pass=1`.
- Start with `num_vec=2`, `exp_sig=16'hEFDF`; pairs (vec 15'h7FFF, resp 1), (vec 0, resp 0) -> `sig` 0xFFFF then 0xEFDF (feedback applied), `pass=1`; rerun with `exp_sig=16'h0000` -> `pass=0`.
- `in_valid` toggling 1,0,1,0,1 for `num_vec=3` -> exactly 3 accepts, `vec_cnt` increments only on valid cycles, `in_ready` stays 1 until the last accept.
- `num_vec=0`, `exp_sig=SEED` -> `in_ready` never asserts, `done=1` two edges after `start`, `pass=1`.
- `start` pulsed mid-run -> ignored, counts continue; `rst_n` low mid-run -> all outputs at reset values within the same cycle, FSM in IDLE.
- Exhaustive sweep of 32768 vectors with responses from the kernel model, `exp_sig` from the reference model -> `pass=1`, `vec_cnt=32768`, `ones_cnt` equal to the model ones count.
